decoder_scan_ctrl: RTL and testbench

Upstream sequencer that drives the 2-bit select of the 2-to-4 line decoder. It steps a 2-bit index through the enabled lines of a 4-bit mask in ascending order, holding each index for a programmable dwell time. It runs either one-shot or continuous, qualifies `sel` with `sel_valid`, and reports completion, wrap-around and pass count to the controlling logic.

---
 rtl/decoder_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl
//   Sequencer for the select input of a 2-to-4 line decoder. After an accepted
//   start it walks a 2-bit index upward through the lines enabled in a latched
//   4-bit mask. Each index is held for a latched dwell time of D cycles.
//   Operation is one-shot or continuous, and the block reports completion,
//   wrap-around and a count of completed passes.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin a scan (accepted only when idle and stop is low)
//   stop       : abort a running scan; takes priority over count expiry
//   mode_cont  : 1 = continuous, 0 = one-shot (latched on accepted start)
//   mask       : enabled decoder lines (latched on accepted start)
//   dwell      : cycles per index, 0 treated as 1 (latched on accepted start)
//   sel        : decoder index; holds its last value when idle
//   sel_valid  : sel is live
//   busy       : scan in progress
//   done       : one-cycle pulse when a one-shot scan completes
//   wrap       : one-cycle pulse on the first cycle of each new continuous pass
//   err        : one-cycle pulse when start is rejected because mask == 0
//   passes     : completed passes since the last accepted start (wraps)
// -----------------------------------------------------------------------------
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int PASS_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               err,
  output logic [PASS_W-1:0]  passes
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]         state_q,  state_d;
  logic [1:0]         sel_q,    sel_d;
  logic [3:0]         mask_q,   mask_d;
  logic               mode_q,   mode_d;
  logic [DWELL_W-1:0] dwl_q,    dwl_d;
  logic [DWELL_W-1:0] cnt_q,    cnt_d;
  logic [PASS_W-1:0]  passes_q, passes_d;
  logic               done_q,   done_d;
  logic               wrap_q,   wrap_d;
  logic               err_q,    err_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [2:0]         nxt;

  // Lowest enabled line; the caller guarantees m != 0.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = i[1:0];
    end
  endfunction

  // {found, index} of the lowest enabled line strictly above cur.
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
    next_above = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) next_above = {1'b1, i[1:0]};
    end
  endfunction

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    dwl_d    = dwl_q;
    cnt_d    = cnt_q;
    passes_d = passes_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    nxt      = next_above(mask_q, sel_q);

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop cancels the start entirely, including err.
        if (start && !stop) begin
          if (mask == 4'b0000) begin
            err_d = 1'b1;
          end else begin
            mask_d   = mask;
            mode_d   = mode_cont;
            dwl_d    = dwell_eff;
            passes_d = '0;
            state_d  = ST_SCAN;
            sel_d    = lowest_set(mask);
            cnt_d    = dwell_eff - DWELL_W'(1);
          end
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nxt[2]) begin
          sel_d = nxt[1:0];
          cnt_d = dwl_q - DWELL_W'(1);
        end else begin
          // Past the highest enabled line: one full pass completed.
          passes_d = passes_q + PASS_W'(1);
          if (mode_q) begin
            sel_d  = lowest_set(mask_q);
            cnt_d  = dwl_q - DWELL_W'(1);
            wrap_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      mask_q   <= 4'b0000;
      mode_q   <= 1'b0;
      dwl_q    <= '0;
      cnt_q    <= '0;
      passes_q <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      dwl_q    <= dwl_d;
      cnt_q    <= cnt_d;
      passes_q <= passes_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  // sel_valid and busy coincide exactly with the SCAN state.
  assign sel       = sel_q;
  assign sel_valid = (state_q == ST_SCAN);
  assign busy      = (state_q == ST_SCAN);
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign passes    = passes_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

  localparam int DWELL_W = 8;
  localparam int PASS_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, stop, mode_cont;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic               sel_valid, busy, done, wrap, err;
  logic [PASS_W-1:0]  passes;

  int errors = 0;
  int checks = 0;

  // Reference model: the list of enabled indices, the position within it and
  // how many cycles the current index has been shown.
  int         m_list[$];
  int         m_pos;
  int         m_held;
  int         m_D;
  bit         m_busy;
  bit         m_cont;
  int         m_sel;
  int         m_passes;
  bit         m_done, m_wrap, m_err;

  decoder_scan_ctrl #(.DWELL_W(DWELL_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
    .mask(mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid), .busy(busy),
    .done(done), .wrap(wrap), .err(err), .passes(passes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_list.delete();
    m_pos = 0; m_held = 0; m_D = 1; m_busy = 0; m_cont = 0;
    m_sel = 0; m_passes = 0; m_done = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_edge();
    m_done = 0; m_wrap = 0; m_err = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        if (mask == 4'b0000) begin
          m_err = 1;
        end else begin
          m_list.delete();
          for (int i = 0; i < 4; i++) if (mask[i]) m_list.push_back(i);
          m_D      = (dwell == 0) ? 1 : int'(dwell);
          m_cont   = mode_cont;
          m_passes = 0;
          m_pos    = 0;
          m_sel    = m_list[0];
          m_held   = 1;
          m_busy   = 1;
        end
      end
    end else if (stop) begin
      m_busy = 0;
    end else if (m_held < m_D) begin
      m_held++;
    end else begin
      m_pos++;
      m_held = 1;
      if (m_pos == m_list.size()) begin
        m_passes = (m_passes + 1) % (1 << PASS_W);
        if (m_cont) begin
          m_pos  = 0;
          m_sel  = m_list[0];
          m_wrap = 1;
        end else begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        m_sel = m_list[m_pos];
      end
    end
  endtask

  task automatic check_all();
    chk("sel",       32'(sel),       32'(m_sel));
    chk("sel_valid", 32'(sel_valid), 32'(m_busy));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("done",      32'(done),      32'(m_done));
    chk("wrap",      32'(wrap),      32'(m_wrap));
    chk("err",       32'(err),       32'(m_err));
    chk("passes",    32'(passes),    32'(m_passes));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic go(input logic [3:0] mk, input int dw, input bit mc);
    mask = mk; dwell = DWELL_W'(dw); mode_cont = mc; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; mode_cont = 0; mask = 0; dwell = 0;
    model_reset();
    #1;
    check_all();
    #13 rst = 1'b0;

    // One-shot, all lines, dwell 1: 0,1,2,3 then done with passes=1.
    go(4'b1111, 1, 1'b0);
    repeat (5) cycle();

    // Continuous 1010, dwell 3: three full passes.
    go(4'b1010, 3, 1'b1);
    repeat (18) cycle();
    chk("passes_after_3", 32'(passes), 32'd3);

    // Stop on second cycle of sel=3.
    stop = 1'b1; cycle(); stop = 1'b0;
    go(4'b1010, 3, 1'b1);
    repeat (4) cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    chk("stop_sel_held", 32'(sel), 32'd3);
    repeat (2) cycle();

    // Rejected start, then single line with dwell 0.
    go(4'b0000, 2, 1'b0);
    cycle();
    go(4'b0100, 0, 1'b0);
    repeat (3) cycle();

    // Start while busy is ignored; start together with stop in idle is ignored.
    go(4'b0110, 2, 1'b1);
    repeat (3) cycle();
    go(4'b1001, 1, 1'b0);
    repeat (6) cycle();

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
    stop = 1'b1; go(4'b0011, 1, 1'b0); stop = 1'b0;
    cycle();

    // Single line continuous, passes wraps 15 -> 0.
    go(4'b0001, 1, 1'b1);
    repeat (17) cycle();
    chk("passes_wrapped", 32'(passes), 32'd1);
    stop = 1'b1; cycle(); stop = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      mask      = 4'($urandom_range(0, 15));
      dwell     = DWELL_W'($urandom_range(0, 3));
      mode_cont = 1'($urandom_range(0, 1));
      cycle();
    end
    start = 0; stop = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

endmodule
